// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stages: per-boundary field widths and stage state encoding.
package pipe_pkg;

    localparam int CTRL_W_FD = 1;
    localparam int DATA_W_FD = 96;
    localparam int CTRL_W_DE = 23;
    localparam int DATA_W_DE = 175;
    localparam int CTRL_W_EM = 8;
    localparam int DATA_W_EM = 101;
    localparam int CTRL_W_MW = 4;
    localparam int DATA_W_MW = 69;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } st_e;

    // The encoding doubles as the held-entry count, so occupancy is the state itself.
    function automatic logic [1:0] occ_of(input st_e st);
        return (st == ST_FULL) ? 2'd2 : (st == ST_ONE) ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter: holds at all-ones, cleared only by asynchronous active-low reset.
module pipe_sat_cnt #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [STAT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Generic elastic pipeline stage: valid/ready handshake, 2-entry skid buffer, synchronous flush.
// Define PIPE_STAT_EN to add saturating stall_cnt / flush_cnt statistics outputs.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DE,
    parameter int DATA_W = DATA_W_DE,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAT_EN
    ,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt
`endif
);

    if (STAT_W < 1) begin : g_bad_stat_w
        $error("pipe_stage_elastic: STAT_W must be at least 1");
    end

    st_e               state;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              in_fire;
    logic              out_fire;

    // Handshake: a beat transfers on a rising edge where valid and ready are both high;
    // in_ready depends only on the state register, never on out_ready.
    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;
    assign occupancy = occ_of(state);

    // Control is zeroed whenever an entry empties; data is left alone to avoid toggling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state     <= ST_ONE;
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (in_fire) begin
                        state     <= ST_FULL;
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                    end else if (out_fire) begin
                        state     <= ST_EMPTY;
                        main_ctrl <= '0;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state     <= ST_ONE;
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                        skid_ctrl <= '0;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    main_ctrl <= '0;
                    skid_ctrl <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_STAT_EN
    pipe_sat_cnt #(.STAT_W(STAT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid & ~out_ready),
        .cnt (stall_cnt)
    );

    pipe_sat_cnt #(.STAT_W(STAT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush & (state != ST_EMPTY)),
        .cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic against a queue-based reference model.
module tb_pipe_stage_elastic;

    localparam int CW = 23;
    localparam int DW = 175;
    localparam int SW = 4;
    localparam int EW = CW + DW;
    localparam int SAT_MAX = (1 << SW) - 1;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_STAT_EN
    logic [SW-1:0] stall_cnt;
    logic [SW-1:0] flush_cnt;
`endif

    pipe_stage_elastic #(
        .CTRL_W (CW),
        .DATA_W (DW),
        .STAT_W (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STAT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: the stage is a FIFO of at most two entries
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] hold_data;
    int            stall_m;
    int            flush_m;
    logic          m_in_fire;

    int checks;
    int errors;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        hold_data = '0;
        stall_m   = 0;
        flush_m   = 0;
        m_in_fire = 1'b0;
    endtask

    task automatic check_outputs();
        int n;
        logic [EW-1:0] head;
        n    = exp_q.size();
        head = (n > 0) ? exp_q[0] : '0;
        check("out_valid", out_valid, n > 0);
        check("in_ready", in_ready, n < 2);
        check("occupancy", occupancy, n);
        check("out_ctrl", out_ctrl, (n > 0) ? head[EW-1:DW] : '0);
        check("out_data", out_data, (n > 0) ? head[DW-1:0] : hold_data);
`ifdef PIPE_STAT_EN
        check("stall_cnt", stall_cnt, stall_m);
        check("flush_cnt", flush_cnt, flush_m);
`endif
    endtask

    task automatic model_update();
        int   n;
        logic o_fire;
        n         = exp_q.size();
        m_in_fire = in_valid && (n < 2);
        o_fire    = (n > 0) && out_ready;
        if (n > 0 && !out_ready && stall_m < SAT_MAX) stall_m++;
        if (flush && n != 0 && flush_m < SAT_MAX) flush_m++;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (o_fire) void'(exp_q.pop_front());
            if (m_in_fire) exp_q.push_back({in_ctrl, in_data});
        end
        if (exp_q.size() > 0) hold_data = exp_q[0][DW-1:0];
    endtask

    // driver: called at a falling edge; checks, drives, predicts, advances one cycle
    task automatic cycle(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic ordy, input logic fl);
        check_outputs();
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic [CW-1:0] c, input logic [DW-1:0] d, input logic ordy);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            cycle(1'b1, c, d, ordy, 1'b0);
            if (m_in_fire) done = 1'b1;
        end
        if (!done) check("offer_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle(input int cycles, input logic ordy);
        for (int k = 0; k < cycles; k++) cycle(1'b0, '0, in_data, ordy, 1'b0);
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    initial begin
        logic          pend;
        logic [CW-1:0] pc;
        logic [DW-1:0] pd;
        logic [DW-1:0] dd;
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b1;
        @(negedge clk);

        // streaming: 8 back-to-back beats with no stall
        for (int i = 0; i < 8; i++) cycle(1'b1, CW'(i), DW'(i * 3), 1'b1, 1'b0);
        // drain: last beat leaves with nothing behind it
        idle(2, 1'b1);

        // stall fill: A to main, B to skid, C waits upstream
        offer(CW'(16'hA), DW'(16'hAAAA), 1'b0);
        offer(CW'(16'hB), DW'(16'hBBBB), 1'b0);
        cycle(1'b1, CW'(16'hC), DW'(16'hCCCC), 1'b0, 1'b0);
        cycle(1'b1, CW'(16'hC), DW'(16'hCCCC), 1'b0, 1'b0);
        offer(CW'(16'hC), DW'(16'hCCCC), 1'b1);
        idle(4, 1'b1);

        // flush while full, D offered in the same cycle
        offer(CW'(16'hE), DW'(16'hEEEE), 1'b0);
        offer(CW'(16'hF), DW'(16'hFFFF), 1'b0);
        cycle(1'b1, CW'(16'hD), DW'(16'hDDDD), 1'b0, 1'b1);
        idle(3, 1'b1);

        // flush while one entry held, D accepted by the handshake but discarded
        offer(CW'(16'h11), DW'(16'h1111), 1'b0);
        cycle(1'b1, CW'(16'hD), DW'(16'hDDDD), 1'b0, 1'b1);
        idle(3, 1'b1);

        // stall long enough to saturate the stall counter
        offer(CW'(16'h22), DW'(16'h2222), 1'b0);
        idle(20, 1'b0);
        idle(2, 1'b1);

        // randomized traffic with flushes and stalls
        pend = 1'b0;
        pc   = '0;
        pd   = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                pc   = CW'($urandom());
                pd   = rand_data();
            end
            cycle(pend, pc, pd, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
            if (m_in_fire) pend = 1'b0;
        end
        idle(3, 1'b1);

        // asynchronous reset in the middle of a full stage
        dd = rand_data();
        offer(CW'(23'h7FFFFF), dd, 1'b0);
        offer(CW'(23'h7FFFFF), dd, 1'b0);
        check_outputs();
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        model_reset();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_ctrl", out_ctrl, '0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_occupancy", occupancy, 2'd0);
        check("rst_out_data", out_data, '0);
        #3;
        rst = 1'b1;
        @(negedge clk);
        offer(CW'(16'h33), DW'(16'h3333), 1'b1);
        idle(3, 1'b1);
        check_outputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
